// File: rtl/led_seq_pkg.sv
// Shared types for the LED pattern sequencer: pattern modes and per-mode seed selection.
package led_seq_pkg;

   typedef enum logic [1:0] {
      ROT_L  = 2'd0,
      ROT_R  = 2'd1,
      BOUNCE = 2'd2,
      BLINK  = 2'd3
   } led_mode_e;

   // Blink starts from all LEDs lit; every other mode starts from LED0 alone.
   function automatic logic seed_full(input led_mode_e m);
      return (m == BLINK);
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Pattern-step prescaler: counts TICK_CYCLES clocks while enabled, strobes on wrap.
module led_tick_gen
   import led_seq_pkg::*;
#(
   parameter int unsigned TICK_CYCLES = 12_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick_pre,
   output logic tick
);

   localparam int unsigned CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;

   assign tick_pre = en && (cnt_q == LAST);
   assign tick     = tick_q;

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         tick_d = tick_pre;
         cnt_d  = tick_pre ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer top: mode tracker, pattern/direction register, output polarity.
// Optional PWM dimming via the LED_PWM_DIM_EN macro (adds the bright port).
module led_pattern_seq
   import led_seq_pkg::*;
#(
   parameter int unsigned N_LED       = 3,
   parameter int unsigned TICK_CYCLES = 12_000_000,
   parameter bit          ACTIVE_LOW  = 1'b1,
   parameter int unsigned PWM_BITS    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                step,
   input  logic [1:0]          mode,
`ifdef LED_PWM_DIM_EN
   input  logic [PWM_BITS-1:0] bright,
`endif
   output logic [N_LED-1:0]    led,
   output logic                tick
);

   led_mode_e        mode_in, mode_q, mode_d;
   logic [N_LED-1:0] pat_q, pat_d;
   logic [N_LED-1:0] rot_l, rot_r, bnc, seed, lit;
   logic             dir_q, dir_d, bnc_dir;
   logic             mode_chg, tick_pre, adv;

   assign mode_in  = led_mode_e'(mode);
   assign mode_chg = (mode_in != mode_q);
   assign adv      = tick_pre || (!en && step);
   assign seed     = seed_full(mode_in) ? '1 : N_LED'(1);

   led_tick_gen #(
      .TICK_CYCLES(TICK_CYCLES)
   ) u_tick (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .clr      (mode_chg),
      .tick_pre (tick_pre),
      .tick     (tick)
   );

   // Modulo wiring makes N_LED=1 rotate onto itself.
   for (genvar gi = 0; gi < N_LED; gi++) begin : g_rot
      assign rot_l[gi] = pat_q[(gi + N_LED - 1) % N_LED];
      assign rot_r[gi] = pat_q[(gi + 1) % N_LED];
   end

   always_comb begin
      bnc     = pat_q;
      bnc_dir = dir_q;
      if (N_LED > 1) begin
         if (!dir_q) begin
            if (pat_q[N_LED-1]) begin
               bnc     = pat_q >> 1;
               bnc_dir = 1'b1;
            end else begin
               bnc = pat_q << 1;
            end
         end else begin
            if (pat_q[0]) begin
               bnc     = pat_q << 1;
               bnc_dir = 1'b0;
            end else begin
               bnc = pat_q >> 1;
            end
         end
      end
   end

   // A mode change reseeds and wins over any advance in the same cycle.
   always_comb begin
      pat_d  = pat_q;
      dir_d  = dir_q;
      mode_d = mode_q;
      if (mode_chg) begin
         mode_d = mode_in;
         pat_d  = seed;
         dir_d  = 1'b0;
      end else if (adv) begin
         case (mode_q)
            ROT_L:   pat_d = rot_l;
            ROT_R:   pat_d = rot_r;
            BOUNCE: begin
               pat_d = bnc;
               dir_d = bnc_dir;
            end
            BLINK:   pat_d = ~pat_q;
            default: pat_d = pat_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q  <= N_LED'(1);
         dir_q  <= 1'b0;
         mode_q <= ROT_L;
      end else begin
         pat_q  <= pat_d;
         dir_q  <= dir_d;
         mode_q <= mode_d;
      end
   end

`ifdef LED_PWM_DIM_EN
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic                pwm_lit_q;

   assign pwm_cnt_d = pwm_cnt_q + 1'b1;

   // Gate is registered so the pins never see a combinational path from bright.
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt_q <= '0;
         pwm_lit_q <= 1'b0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         pwm_lit_q <= (pwm_cnt_d < bright);
      end
   end

   assign lit = pat_q & {N_LED{pwm_lit_q}};
`else
   if (PWM_BITS < 1) begin : g_pwm_bits_unused
   end

   assign lit = pat_q;
`endif

   assign led = ACTIVE_LOW ? ~lit : lit;

endmodule
